rhs2116_link_supervisor: RTL and testbench
==========================================

// Module: rhs2116_link_supervisor
// PURPOSE
//   Link bring-up and recovery controller for the RHS2116 receive decoder. Sits beside the
//   decoder in the clk_sys domain and owns its reset: it sequences reset -> CDR lock ->
//   frame acquisition -> link up. It watches CDR lock, frame errors and sync loss, and
//   re-runs acquisition with bounded retries. It also reports link state, counters and an
//   interrupt pulse to the host.
// PARAMETERS
//   RST_CYCLES    16      cycles decoder_rst_n is held low per (re)start attempt
//   LOCK_TIMEOUT  65536   cycles allowed in WAIT_LOCK or ACQUIRE before the attempt fails
//   GOOD_FRAMES   16      consecutive clean frames required to declare link up
//   ERR_WINDOW    4096    error-rate window length in cycles (state UP)
//   MAX_ERRS      8       frame errors inside one window that force a resync
//   MAX_RETRY     4       failed attempts before entering FAULT
//   CNT_W         16      width of err_total
// PORTS
//   clk_sys        in   1      system clock, 100MHz
//   rst_n          in   1      asynchronous active-low reset
//   enable         in   1      host enable; 0 forces IDLE
//   cdr_locked     in   1      CDR lock from clk_link domain (asynchronous; 2-FF synchronised here)
//   frame_error    in   1      decoder frame error pulse (clk_sys)
//   sync_lost      in   1      decoder sync-lost pulse/level (clk_sys)
//   data_valid     in   1      decoder output word strobe (clk_sys)
//   decoder_rst_n  out  1      active-low reset to decoder (CDR, frame sync, FIFO)
//   link_up        out  1      1 only in state UP
//   link_state     out  3      IDLE=0 RESET=1 WAIT_LOCK=2 ACQUIRE=3 UP=4 FAULT=5
//   retry_cnt      out  8      failed attempts since last UP or IDLE (saturates at 255)
//   err_total      out  CNT_W  frame_error pulses seen in ACQUIRE or UP; saturating; cleared in IDLE
//   fault          out  1      1 only in state FAULT
//   status_irq     out  1      1-cycle pulse on entering UP, leaving UP, or entering FAULT
// BEHAVIOUR
//   Reset values: state IDLE, decoder_rst_n=0, link_up=0, retry_cnt=0, err_total=0, fault=0,
//     status_irq=0, all timers 0.
//   lock_s = cdr_locked after 2 flops; the decision latency on lock is 2 cycles.
//   All outputs are registered; state-derived outputs are valid in the cycle after the transition.
//   enable=0 in any state -> IDLE next cycle. This has priority over every other transition.
//   IDLE: decoder_rst_n=0; retry_cnt, err_total cleared. enable=1 -> RESET.
//   RESET: decoder_rst_n=0 for exactly RST_CYCLES cycles -> WAIT_LOCK (timer cleared).
//   WAIT_LOCK: lock_s=1 -> ACQUIRE. Timer reaches LOCK_TIMEOUT-1 -> attempt fails.
//   ACQUIRE: good_cnt increments on data_valid when frame_error=0.
//     frame_error or sync_lost sets good_cnt to 0; data_valid with frame_error in the same cycle
//       counts as an error.
//     good_cnt reaching GOOD_FRAMES -> UP; on entry to UP, retry_cnt is set to 0.
//     lock_s=0 or the timeout -> attempt fails.
//   UP: window timer free-runs; win_errs is cleared when the window wraps.
//     If an error lands in the wrap cycle, that error counts as the first error of the new window.
//     lock_s=0, sync_lost=1, or win_errs reaching MAX_ERRS -> attempt fails.
//   Attempt fails: retry_cnt+1. If the new value >= MAX_RETRY -> FAULT, else -> RESET.
//     Priority when several apply in one cycle: lock loss > sync_lost > error threshold > timeout.
//   FAULT: decoder_rst_n=0; sticky until enable=0.
//   decoder_rst_n=1 only in WAIT_LOCK, ACQUIRE and UP.
//   The supervisor ignores frame_error, sync_lost and data_valid while decoder_rst_n=0.
//   Async rst_n assertion mid-operation returns every output to its reset value immediately.
//   Counters saturate and never wrap.
// STRUCTURE
//   Shared package rhs2116_link_pkg: link_state encodings (3-bit localparams) and the
//     LINK_STATE_W constant.
//   One sub-module, sync_2ff, used for cdr_locked; the rest is a single FSM with its own counters.
// TESTING
//   (Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=64, GOOD_FRAMES=4, ERR_WINDOW=32,
//    MAX_ERRS=3, MAX_RETRY=2.)
//   1. enable=1; raise cdr_locked at cycle 10; send 4 clean data_valid
//        -> decoder_rst_n low for 4 cycles; then states 2 -> 3 -> 4;
//           link_up=1; one status_irq pulse; retry_cnt=0.
//   2. Hold cdr_locked=0 -> two 64-cycle timeouts; retry_cnt=2; link_state=5; fault=1;
//      status_irq pulse. Then enable=0 -> IDLE, retry_cnt=0.
//   3. In UP, 3 frame_error pulses within 32 cycles
//        -> RESET, retry_cnt=1, status_irq pulse, err_total=3.
//      2 errors per window do not trigger a resync.
//   4. In ACQUIRE, after 3 good frames send frame_error and data_valid together
//        -> good_cnt restarts; UP only after 4 further clean frames.
//   5. In UP, drop cdr_locked -> state RESET exactly 3 cycles later (2 sync + 1 registered).
//   6. Assert rst_n low mid-ACQUIRE -> all outputs at their reset values; link_state=0.

Source files
------------

// File: rtl/rhs2116_link_pkg.sv
// ----------------------------------------------------------------------------
// rhs2116_link_pkg
//   Shared definitions for the RHS2116 link supervisor: the 3-bit link_state
//   encodings reported to the host, the matching FSM state type, and a small
//   helper used to size the shared timer.
// ----------------------------------------------------------------------------
package rhs2116_link_pkg;

    localparam int LINK_STATE_W = 3;

    localparam logic [LINK_STATE_W-1:0] LS_IDLE      = 3'd0;
    localparam logic [LINK_STATE_W-1:0] LS_RESET     = 3'd1;
    localparam logic [LINK_STATE_W-1:0] LS_WAIT_LOCK = 3'd2;
    localparam logic [LINK_STATE_W-1:0] LS_ACQUIRE   = 3'd3;
    localparam logic [LINK_STATE_W-1:0] LS_UP        = 3'd4;
    localparam logic [LINK_STATE_W-1:0] LS_FAULT     = 3'd5;

    typedef enum logic [LINK_STATE_W-1:0] {
        ST_IDLE      = LS_IDLE,
        ST_RESET     = LS_RESET,
        ST_WAIT_LOCK = LS_WAIT_LOCK,
        ST_ACQUIRE   = LS_ACQUIRE,
        ST_UP        = LS_UP,
        ST_FAULT     = LS_FAULT
    } link_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rhs2116_link_supervisor_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single slow level crossing into clk.
// Ports
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset (output resets to 0)
//   d      in   asynchronous input level
//   q      out  synchronised level, 2 cycles of latency
// ----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rhs2116_link_supervisor.sv
// ----------------------------------------------------------------------------
// rhs2116_link_supervisor
//   Bring-up / recovery controller for the RHS2116 receive decoder. Owns the
//   decoder reset and walks IDLE -> RESET -> WAIT_LOCK -> ACQUIRE -> UP,
//   retrying failed attempts up to MAX_RETRY times before parking in FAULT.
// Ports
//   clk_sys        in   system clock
//   rst_n          in   asynchronous active-low reset
//   enable         in   host enable; 0 forces IDLE
//   cdr_locked     in   CDR lock (asynchronous, synchronised here)
//   frame_error    in   decoder frame error pulse
//   sync_lost      in   decoder sync-lost pulse/level
//   data_valid     in   decoder output word strobe
//   decoder_rst_n  out  active-low decoder reset
//   link_up        out  1 in UP
//   link_state     out  current state encoding (see rhs2116_link_pkg)
//   retry_cnt      out  failed attempts since last UP or IDLE (saturating)
//   err_total      out  frame errors seen in ACQUIRE/UP (saturating)
//   fault          out  1 in FAULT
//   status_irq     out  1-cycle pulse on entering UP, leaving UP, entering FAULT
// ----------------------------------------------------------------------------
module rhs2116_link_supervisor
    import rhs2116_link_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int GOOD_FRAMES  = 16,
    parameter int ERR_WINDOW   = 4096,
    parameter int MAX_ERRS     = 8,
    parameter int MAX_RETRY    = 4,
    parameter int CNT_W        = 16
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    cdr_locked,
    input  logic                    frame_error,
    input  logic                    sync_lost,
    input  logic                    data_valid,
    output logic                    decoder_rst_n,
    output logic                    link_up,
    output logic [LINK_STATE_W-1:0] link_state,
    output logic [7:0]              retry_cnt,
    output logic [CNT_W-1:0]        err_total,
    output logic                    fault,
    output logic                    status_irq
);

    // One timer serves RESET length, WAIT_LOCK/ACQUIRE timeout and UP window.
    localparam int TMR_W  = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, ERR_WINDOW) + 1);
    localparam int GOOD_W = $clog2(GOOD_FRAMES + 1);
    localparam int WERR_W = $clog2(MAX_ERRS + 1);

    localparam logic [TMR_W-1:0]  RST_LAST  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TO_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  WIN_LAST  = TMR_W'(ERR_WINDOW - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_FRAMES - 1);
    localparam logic [WERR_W-1:0] ERR_LIM   = WERR_W'(MAX_ERRS);
    localparam logic [7:0]        RETRY_LIM = 8'(MAX_RETRY);

    link_state_e       state, state_nxt;
    logic              lock_s;
    logic [TMR_W-1:0]  timer;
    logic [GOOD_W-1:0] good_cnt;
    logic [WERR_W-1:0] win_errs, win_errs_inc;
    logic [7:0]        retry_inc;
    logic              fe, sl, dv, clean_frame;
    logic              win_wrap, err_hit, attempt_fail, irq_nxt;

    sync_2ff u_lock_sync (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .d     (cdr_locked),
        .q     (lock_s)
    );

    // Decoder-side strobes are meaningless while we hold it in reset.
    assign fe          = frame_error & decoder_rst_n;
    assign sl          = sync_lost   & decoder_rst_n;
    assign dv          = data_valid  & decoder_rst_n;
    assign clean_frame = dv & ~fe & ~sl;

    // An error in the wrap cycle is the first error of the new window.
    assign win_wrap     = (timer == WIN_LAST);
    assign win_errs_inc = win_wrap ? WERR_W'(1) : win_errs + 1'b1;
    assign err_hit      = fe & (win_errs_inc >= ERR_LIM);

    assign retry_inc = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;

    assign irq_nxt = (state_nxt != state) &&
                     (state_nxt == ST_UP || state == ST_UP || state_nxt == ST_FAULT);

    assign link_state = state;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        attempt_fail = 1'b0;
        case (state)
            ST_IDLE:      if (enable) state_nxt = ST_RESET;
            ST_RESET:     if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_s)                 state_nxt = ST_ACQUIRE;
                else if (timer == TO_LAST)  attempt_fail = 1'b1;
            end
            ST_ACQUIRE: begin
                if (!lock_s)                                     attempt_fail = 1'b1;
                else if (clean_frame && good_cnt == GOOD_LAST)   state_nxt = ST_UP;
                else if (timer == TO_LAST)                       attempt_fail = 1'b1;
            end
            ST_UP: begin
                // Lock loss > sync_lost > error threshold; all end the attempt.
                if (!lock_s)      attempt_fail = 1'b1;
                else if (sl)      attempt_fail = 1'b1;
                else if (err_hit) attempt_fail = 1'b1;
            end
            ST_FAULT:     state_nxt = ST_FAULT;
            default:      state_nxt = ST_IDLE;
        endcase
        if (attempt_fail) state_nxt = (retry_inc >= RETRY_LIM) ? ST_FAULT : ST_RESET;
        if (!enable)      state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            good_cnt      <= '0;
            win_errs      <= '0;
            retry_cnt     <= '0;
            err_total     <= '0;
            decoder_rst_n <= 1'b0;
            link_up       <= 1'b0;
            fault         <= 1'b0;
            status_irq    <= 1'b0;
        end else begin
            state         <= state_nxt;
            decoder_rst_n <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_ACQUIRE) ||
                             (state_nxt == ST_UP);
            link_up       <= (state_nxt == ST_UP);
            fault         <= (state_nxt == ST_FAULT);
            status_irq    <= irq_nxt;

            // Each state starts its own timing from zero; UP free-runs the window.
            if (state_nxt != state)                      timer <= '0;
            else if (state == ST_UP)                     timer <= win_wrap ? '0 : timer + 1'b1;
            else if (state == ST_IDLE || state == ST_FAULT) timer <= '0;
            else                                         timer <= timer + 1'b1;

            if (state != ST_ACQUIRE || fe || sl) good_cnt <= '0;
            else if (dv)                         good_cnt <= good_cnt + 1'b1;

            if (state != ST_UP)  win_errs <= '0;
            else if (win_wrap)   win_errs <= fe ? win_errs_inc : '0;
            else if (fe)         win_errs <= win_errs_inc;

            if (state_nxt == ST_IDLE) begin
                retry_cnt <= '0;
                err_total <= '0;
            end else begin
                if (state_nxt == ST_UP && state != ST_UP) retry_cnt <= '0;
                else if (attempt_fail)                    retry_cnt <= retry_inc;
                if (fe && (state == ST_ACQUIRE || state == ST_UP) && err_total != '1)
                    err_total <= err_total + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rhs2116_link_supervisor.sv
// ----------------------------------------------------------------------------
// tb_rhs2116_link_supervisor
//   Directed bench for rhs2116_link_supervisor with small parameters:
//   RST_CYCLES=4, LOCK_TIMEOUT=64, GOOD_FRAMES=4, ERR_WINDOW=32, MAX_ERRS=3,
//   MAX_RETRY=2. A vector table covers bring-up cycle by cycle; hand-written
//   sequences cover error windows, retries, FAULT, lock loss and async reset.
// ----------------------------------------------------------------------------
module tb_rhs2116_link_supervisor;

    localparam int CNT_W = 16;

    logic             clk_sys = 1'b0;
    logic             rst_n, enable, cdr_locked, frame_error, sync_lost, data_valid;
    logic             decoder_rst_n, link_up, fault, status_irq;
    logic [2:0]       link_state;
    logic [7:0]       retry_cnt;
    logic [CNT_W-1:0] err_total;

    int n_tests = 0;
    int n_fail  = 0;

    rhs2116_link_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (64),
        .GOOD_FRAMES  (4),
        .ERR_WINDOW   (32),
        .MAX_ERRS     (3),
        .MAX_RETRY    (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .enable        (enable),
        .cdr_locked    (cdr_locked),
        .frame_error   (frame_error),
        .sync_lost     (sync_lost),
        .data_valid    (data_valid),
        .decoder_rst_n (decoder_rst_n),
        .link_up       (link_up),
        .link_state    (link_state),
        .retry_cnt     (retry_cnt),
        .err_total     (err_total),
        .fault         (fault),
        .status_irq    (status_irq)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       en, lock, fe, sl, dv;
        logic [2:0] st;
        logic       lu, drst, irq;
        logic [7:0] retry;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic en, lock, fe, sl, dv, input logic [2:0] st,
                                input logic lu, drst, irq, input logic [7:0] retry);
        vec_t v;
        v.en = en; v.lock = lock; v.fe = fe; v.sl = sl; v.dv = dv;
        v.st = st; v.lu = lu; v.drst = drst; v.irq = irq; v.retry = retry;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic lu,
                              input logic drst, input logic irq, input logic flt,
                              input logic [7:0] rt);
        check({tag, " link_state"},    32'(link_state),    32'(st));
        check({tag, " link_up"},       32'(link_up),       32'(lu));
        check({tag, " decoder_rst_n"}, 32'(decoder_rst_n), 32'(drst));
        check({tag, " status_irq"},    32'(status_irq),    32'(irq));
        check({tag, " fault"},         32'(fault),         32'(flt));
        check({tag, " retry_cnt"},     32'(retry_cnt),     32'(rt));
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic step(input logic fe, input logic sl, input logic dv);
        frame_error = fe; sync_lost = sl; data_valid = dv;
        tick();
        frame_error = 1'b0; sync_lost = 1'b0; data_valid = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (link_state != st && n < budget) begin
            tick();
            n++;
        end
        check({tag, " reached state"}, 32'(link_state), 32'(st));
    endtask

    // Holds for n edges and checks the state never moved.
    task automatic hold_state(input string tag, input logic [2:0] st, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (link_state != st) bad++;
        end
        check({tag, " cycles off-state"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //              en lk fe sl dv  st  lu drst irq retry
        vecs[0]  = mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 8'd0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 8'd0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 8'd0);
        vecs[3]  = mk(1, 0, 1, 1, 1, 3'd1, 0, 0, 0, 8'd0);  // strobes ignored in reset
        vecs[4]  = mk(1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 8'd0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 3'd2, 0, 1, 0, 8'd0);
        vecs[6]  = mk(1, 1, 0, 0, 0, 3'd2, 0, 1, 0, 8'd0);  // lock rises, 2-flop delay
        vecs[7]  = mk(1, 1, 0, 0, 0, 3'd2, 0, 1, 0, 8'd0);
        vecs[8]  = mk(1, 1, 0, 0, 0, 3'd3, 0, 1, 0, 8'd0);
        vecs[9]  = mk(1, 1, 0, 0, 1, 3'd3, 0, 1, 0, 8'd0);
        vecs[10] = mk(1, 1, 0, 0, 1, 3'd3, 0, 1, 0, 8'd0);
        vecs[11] = mk(1, 1, 0, 0, 1, 3'd3, 0, 1, 0, 8'd0);
        vecs[12] = mk(1, 1, 0, 0, 1, 3'd4, 1, 1, 1, 8'd0);  // 4th clean frame -> UP
        vecs[13] = mk(1, 1, 0, 0, 0, 3'd4, 1, 1, 0, 8'd0);

        rst_n = 1'b0; enable = 1'b0; cdr_locked = 1'b0;
        frame_error = 1'b0; sync_lost = 1'b0; data_valid = 1'b0;
        tick();
        tick();
        check_outs("reset", 3'd0, 0, 0, 0, 0, 8'd0);
        check("reset err_total", 32'(err_total), 32'd0);
        rst_n = 1'b1;

        // Bring-up, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            enable = vecs[i].en; cdr_locked = vecs[i].lock;
            frame_error = vecs[i].fe; sync_lost = vecs[i].sl; data_valid = vecs[i].dv;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].lu, vecs[i].drst,
                       vecs[i].irq, 1'b0, vecs[i].retry);
        end
        frame_error = 1'b0; sync_lost = 1'b0; data_valid = 1'b0;
        check("bringup err_total", 32'(err_total), 32'd0);

        // Three errors inside one window force a resync.
        step(1, 0, 0);
        check("err1 state", 32'(link_state), 32'd4);
        step(1, 0, 0);
        check("err2 state", 32'(link_state), 32'd4);
        step(1, 0, 0);
        check_outs("err3", 3'd1, 0, 0, 1, 0, 8'd1);
        check("err3 err_total", 32'(err_total), 32'd3);
        step(1, 0, 0);
        check("reset-ignored err_total", 32'(err_total), 32'd3);
        check("reset-ignored irq", 32'(status_irq), 32'd0);

        // Clean frame count restarts after data_valid together with frame_error.
        wait_state("acq2", 3'd3, 20);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check("acq 3 good state", 32'(link_state), 32'd3);
        step(1, 0, 1);
        check("acq dv+fe state", 32'(link_state), 32'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check("acq 3 more state", 32'(link_state), 32'd3);
        step(0, 0, 1);
        check_outs("acq up", 3'd4, 1, 1, 1, 0, 8'd0);
        check("acq up err_total", 32'(err_total), 32'd4);

        // Window boundary: 2 errors in window A, then errors on the wrap edge and
        // the next two edges. The wrap error opens window B, so only the third
        // error of window B resyncs.
        step(1, 0, 0);
        step(1, 0, 0);
        check("win A 2 errs state", 32'(link_state), 32'd4);
        for (int i = 0; i < 29; i++) step(0, 0, 0);
        step(1, 0, 0);
        check("wrap err state", 32'(link_state), 32'd4);
        step(1, 0, 0);
        check("win B 2 errs state", 32'(link_state), 32'd4);
        step(1, 0, 0);
        check_outs("win B 3 errs", 3'd1, 0, 0, 1, 0, 8'd1);
        check("win err_total", 32'(err_total), 32'd9);

        // Lock loss in UP reaches RESET exactly 3 edges later.
        wait_state("acq3", 3'd3, 20);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        check_outs("up3", 3'd4, 1, 1, 1, 0, 8'd0);
        cdr_locked = 1'b0;
        tick();
        check("lockloss +1 state", 32'(link_state), 32'd4);
        tick();
        check("lockloss +2 state", 32'(link_state), 32'd4);
        tick();
        check_outs("lockloss +3", 3'd1, 0, 0, 1, 0, 8'd1);

        enable = 1'b0;
        tick();
        check_outs("disable", 3'd0, 0, 0, 0, 0, 8'd0);
        check("disable err_total", 32'(err_total), 32'd0);

        // No lock: two 64-cycle timeouts lead to FAULT.
        enable = 1'b1;
        wait_state("to1 wait", 3'd2, 10);
        hold_state("to1", 3'd2, 63);
        tick();
        check_outs("to1 fail", 3'd1, 0, 0, 0, 0, 8'd1);
        wait_state("to2 wait", 3'd2, 10);
        hold_state("to2", 3'd2, 63);
        tick();
        check_outs("to2 fault", 3'd5, 0, 0, 1, 1, 8'd2);
        cdr_locked = 1'b1;
        hold_state("fault sticky", 3'd5, 10);
        check_outs("fault held", 3'd5, 0, 0, 0, 1, 8'd2);
        enable = 1'b0;
        tick();
        check_outs("fault exit", 3'd0, 0, 0, 0, 0, 8'd0);

        // Async reset mid-ACQUIRE.
        enable = 1'b1;
        wait_state("acq4", 3'd3, 20);
        step(1, 0, 0);
        check("pre-rst err_total", 32'(err_total), 32'd1);
        check("pre-rst drst", 32'(decoder_rst_n), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("async rst", 3'd0, 0, 0, 0, 0, 8'd0);
        check("async rst err_total", 32'(err_total), 32'd0);
        tick();
        enable = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("post-rst state", 32'(link_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
